// File: rtl/apb_nslv_pkg.sv
// Shared types, response codes and strobe helper for the AHB-lite to APB bridge.
package apb_nslv_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CAPT,
    ST_SETUP,
    ST_ACCESS,
    ST_DONE,
    ST_ERR1,
    ST_ERR2
  } state_t;

  localparam logic [1:0] HRESP_OKAY = 2'b00;
  localparam logic [1:0] HRESP_ERR  = 2'b01;

  // Index registers are sized for the largest supported slot count.
  localparam int MAX_SLV   = 16;
  localparam int SLV_IDX_W = $clog2(MAX_SLV);

  function automatic logic [3:0] pstrb_gen(input logic [2:0] size, input logic [1:0] addr);
    logic [3:0] strb;
    case (size)
      3'd0:    strb = 4'b0001 << addr;
      3'd1:    strb = 4'b0011 << {addr[1], 1'b0};
      default: strb = 4'hF;
    endcase
    return strb;
  endfunction

endpackage

// File: rtl/apb_nslv_decode.sv
// Combinational slot decoder: region match, slot index and one-hot select.
module apb_nslv_decode
  import apb_nslv_pkg::*;
#(
  parameter int                NUM_SLV   = 8,
  parameter int                ADDR_W    = 40,
  parameter int                SEL_LSB   = 12,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 40'h00_1000_0000
) (
  input  logic [ADDR_W-1:0]    haddr,
  input  logic [2:0]           hsize,
  output logic                 hit,
  output logic [SLV_IDX_W-1:0] idx,
  output logic [NUM_SLV-1:0]   onehot
);

  // A single-slot bridge still reserves one index bit so the slice stays legal.
  localparam int SEL_W  = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
  localparam int UP_LSB = SEL_LSB + SEL_W;

  logic [SEL_W-1:0] sel;
  logic             base_match;
  logic             idx_ok;
  logic             size_ok;

  assign sel        = haddr[SEL_LSB +: SEL_W];
  assign base_match = (haddr[ADDR_W-1:UP_LSB] == BASE_ADDR[ADDR_W-1:UP_LSB]);
  assign idx_ok     = (int'(sel) < NUM_SLV);
  assign size_ok    = (hsize <= 3'd2);
  assign hit        = base_match & idx_ok & size_ok;
  assign idx        = SLV_IDX_W'(sel);

  for (genvar gi = 0; gi < NUM_SLV; gi++) begin : g_onehot
    assign onehot[gi] = hit && (int'(sel) == gi);
  end

endmodule

// File: rtl/apb_nslv_bridge.sv
// AHB-lite slave to N-slot APB3/4 master with wait states, error mapping and PREADY timeout.
module apb_nslv_bridge
  import apb_nslv_pkg::*;
#(
  parameter int                NUM_SLV     = 8,
  parameter int                ADDR_W      = 40,
  parameter int                SEL_LSB     = 12,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = 40'h00_1000_0000,
  parameter int                TIMEOUT_CYC = 256
) (
  input  logic                  hclk,
  input  logic                  hrst_b,
  input  logic                  harb_apb_hsel,
  input  logic [ADDR_W-1:0]     harb_xx_haddr,
  input  logic [1:0]            harb_xx_htrans,
  input  logic                  harb_xx_hwrite,
  input  logic [2:0]            harb_xx_hsize,
  input  logic [31:0]           harb_xx_hwdata,
  input  logic                  harb_xx_hready_in,
  output logic [31:0]           apb_harb_hrdata,
  output logic                  apb_harb_hready,
  output logic [1:0]            apb_harb_hresp,
  output logic [ADDR_W-1:0]     apb_xx_paddr,
  output logic                  apb_xx_penable,
  output logic                  apb_xx_pwrite,
  output logic [31:0]           apb_xx_pwdata,
  output logic [3:0]            apb_xx_pstrb,
  output logic [NUM_SLV-1:0]    psel_vec,
  input  logic [NUM_SLV*32-1:0] prdata_vec,
  input  logic [NUM_SLV-1:0]    pready_vec,
  input  logic [NUM_SLV-1:0]    pslverr_vec,
  output logic                  timeout_pulse
);

  localparam int TO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

  state_t                state_reg;
  logic [ADDR_W-1:0]     addr_reg;
  logic                  write_reg;
  logic [2:0]            size_reg;
  logic [SLV_IDX_W-1:0]  idx_reg;
  logic [NUM_SLV-1:0]    slot_oh_reg;
  logic [TO_W-1:0]       to_cnt_reg;

  logic [31:0]           hrdata_reg;
  logic                  hready_reg;
  logic [1:0]            hresp_reg;
  logic [ADDR_W-1:0]     paddr_reg;
  logic                  penable_reg;
  logic                  pwrite_reg;
  logic [31:0]           pwdata_reg;
  logic [3:0]            pstrb_reg;
  logic [NUM_SLV-1:0]    psel_reg;
  logic                  timeout_reg;

  logic                  dec_hit;
  logic [SLV_IDX_W-1:0]  dec_idx;
  logic [NUM_SLV-1:0]    dec_oh;
  logic                  accept;
  logic                  unused_htrans0;

  // Slave-side vectors padded to the maximum slot count so the 4-bit index always fits.
  logic [MAX_SLV-1:0]    pready_pad;
  logic [MAX_SLV-1:0]    pslverr_pad;
  logic [MAX_SLV*32-1:0] prdata_pad;
  logic                  pready_sel;
  logic                  pslverr_sel;
  logic [31:0]           prdata_sel;

  apb_nslv_decode #(
    .NUM_SLV   (NUM_SLV),
    .ADDR_W    (ADDR_W),
    .SEL_LSB   (SEL_LSB),
    .BASE_ADDR (BASE_ADDR)
  ) u_decode (
    .haddr  (harb_xx_haddr),
    .hsize  (harb_xx_hsize),
    .hit    (dec_hit),
    .idx    (dec_idx),
    .onehot (dec_oh)
  );

  assign unused_htrans0 = harb_xx_htrans[0];
  assign accept = harb_apb_hsel & harb_xx_htrans[1] & harb_xx_hready_in & hready_reg &
                  ((state_reg == ST_IDLE) | (state_reg == ST_DONE) | (state_reg == ST_ERR2));

  assign pready_pad  = MAX_SLV'(pready_vec);
  assign pslverr_pad = MAX_SLV'(pslverr_vec);
  assign prdata_pad  = (MAX_SLV*32)'(prdata_vec);
  assign pready_sel  = pready_pad[idx_reg];
  assign pslverr_sel = pslverr_pad[idx_reg];
  assign prdata_sel  = prdata_pad[{idx_reg, 5'd0} +: 32];

  always_ff @(posedge hclk or negedge hrst_b) begin
    if (!hrst_b) begin
      state_reg   <= ST_IDLE;
      addr_reg    <= '0;
      write_reg   <= 1'b0;
      size_reg    <= 3'd0;
      idx_reg     <= '0;
      slot_oh_reg <= '0;
      to_cnt_reg  <= '0;
      hrdata_reg  <= 32'h0;
      hready_reg  <= 1'b1;
      hresp_reg   <= HRESP_OKAY;
      paddr_reg   <= '0;
      penable_reg <= 1'b0;
      pwrite_reg  <= 1'b0;
      pwdata_reg  <= 32'h0;
      pstrb_reg   <= 4'h0;
      psel_reg    <= '0;
      timeout_reg <= 1'b0;
    end else begin
      timeout_reg <= 1'b0;
      case (state_reg)
        ST_IDLE, ST_DONE, ST_ERR2: begin
          state_reg  <= ST_IDLE;
          hready_reg <= 1'b1;
          hresp_reg  <= HRESP_OKAY;
          if (accept) begin
            addr_reg    <= harb_xx_haddr;
            write_reg   <= harb_xx_hwrite;
            size_reg    <= harb_xx_hsize;
            idx_reg     <= dec_idx;
            slot_oh_reg <= dec_oh;
            hready_reg  <= 1'b0;
            if (dec_hit) begin
              state_reg <= ST_CAPT;
            end else begin
              state_reg <= ST_ERR1;
              hresp_reg <= HRESP_ERR;
            end
          end
        end
        ST_CAPT: begin
          // hwdata is only valid in the AHB data phase, i.e. this cycle.
          pwdata_reg  <= harb_xx_hwdata;
          paddr_reg   <= addr_reg;
          pwrite_reg  <= write_reg;
          pstrb_reg   <= write_reg ? pstrb_gen(size_reg, addr_reg[1:0]) : 4'h0;
          psel_reg    <= slot_oh_reg;
          penable_reg <= 1'b0;
          state_reg   <= ST_SETUP;
        end
        ST_SETUP: begin
          penable_reg <= 1'b1;
          to_cnt_reg  <= '0;
          state_reg   <= ST_ACCESS;
        end
        ST_ACCESS: begin
          if (pready_sel) begin
            psel_reg    <= '0;
            penable_reg <= 1'b0;
            if (pslverr_sel) begin
              state_reg <= ST_ERR1;
              hresp_reg <= HRESP_ERR;
            end else begin
              state_reg  <= ST_DONE;
              hready_reg <= 1'b1;
              hresp_reg  <= HRESP_OKAY;
              hrdata_reg <= prdata_sel;
            end
          end else if ((TIMEOUT_CYC != 0) && (to_cnt_reg == TO_LAST)) begin
            psel_reg    <= '0;
            penable_reg <= 1'b0;
            timeout_reg <= 1'b1;
            state_reg   <= ST_ERR1;
            hresp_reg   <= HRESP_ERR;
          end else begin
            to_cnt_reg <= to_cnt_reg + TO_W'(1);
          end
        end
        ST_ERR1: begin
          hready_reg <= 1'b1;
          hresp_reg  <= HRESP_ERR;
          state_reg  <= ST_ERR2;
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign apb_harb_hrdata = hrdata_reg;
  assign apb_harb_hready = hready_reg;
  assign apb_harb_hresp  = hresp_reg;
  assign apb_xx_paddr    = paddr_reg;
  assign apb_xx_penable  = penable_reg;
  assign apb_xx_pwrite   = pwrite_reg;
  assign apb_xx_pwdata   = pwdata_reg;
  assign apb_xx_pstrb    = pstrb_reg;
  assign psel_vec        = psel_reg;
  assign timeout_pulse   = timeout_reg;

endmodule

// File: tb/tb_apb_nslv_bridge.sv
// Randomised and directed checks of apb_nslv_bridge against a cycle-phase model of AHB/APB transfers.
`timescale 1ns/1ps
module tb_apb_nslv_bridge;

  localparam int          NUM_SLV = 8;
  localparam int          ADDR_W  = 40;
  localparam int          TO      = 16;
  localparam logic [39:0] BASE    = 40'h00_1000_0000;

  logic                  hclk = 1'b0;
  logic                  hrst_b = 1'b0;
  logic                  hsel = 1'b0;
  logic [ADDR_W-1:0]     haddr = '0;
  logic [1:0]            htrans = 2'b00;
  logic                  hwrite = 1'b0;
  logic [2:0]            hsize = 3'd0;
  logic [31:0]           hwdata = 32'h0;
  logic                  hready_in = 1'b1;
  logic [31:0]           hrdata;
  logic                  hready;
  logic [1:0]            hresp;
  logic [ADDR_W-1:0]     paddr;
  logic                  penable;
  logic                  pwrite;
  logic [31:0]           pwdata;
  logic [3:0]            pstrb;
  logic [NUM_SLV-1:0]    psel_vec;
  logic [NUM_SLV*32-1:0] prdata_vec;
  logic [NUM_SLV-1:0]    pready_vec;
  logic [NUM_SLV-1:0]    pslverr_vec;
  logic                  timeout_pulse;

  typedef struct {
    logic [39:0] addr;
    logic [2:0]  size;
    logic        wr;
    logic [31:0] wdata;
    int          waits;
    logic        err;
  } xfer_t;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] slot_data [NUM_SLV];
  int          cur_waits = 0;
  int          acc_cnt = 0;
  logic        cur_err = 1'b0;
  logic [31:0] last_rdata = 32'h0;

  always #5 hclk = ~hclk;

  // Slave model: every slot becomes ready after cur_waits low-PREADY ACCESS cycles.
  assign pready_vec  = {NUM_SLV{acc_cnt > cur_waits}};
  assign pslverr_vec = {NUM_SLV{cur_err}};
  always_comb begin
    prdata_vec = '0;
    for (int i = 0; i < NUM_SLV; i++) prdata_vec[32*i +: 32] = slot_data[i];
  end

  apb_nslv_bridge #(
    .NUM_SLV     (NUM_SLV),
    .ADDR_W      (ADDR_W),
    .SEL_LSB     (12),
    .BASE_ADDR   (BASE),
    .TIMEOUT_CYC (TO)
  ) dut (
    .hclk              (hclk),
    .hrst_b            (hrst_b),
    .harb_apb_hsel     (hsel),
    .harb_xx_haddr     (haddr),
    .harb_xx_htrans    (htrans),
    .harb_xx_hwrite    (hwrite),
    .harb_xx_hsize     (hsize),
    .harb_xx_hwdata    (hwdata),
    .harb_xx_hready_in (hready_in),
    .apb_harb_hrdata   (hrdata),
    .apb_harb_hready   (hready),
    .apb_harb_hresp    (hresp),
    .apb_xx_paddr      (paddr),
    .apb_xx_penable    (penable),
    .apb_xx_pwrite     (pwrite),
    .apb_xx_pwdata     (pwdata),
    .apb_xx_pstrb      (pstrb),
    .psel_vec          (psel_vec),
    .prdata_vec        (prdata_vec),
    .pready_vec        (pready_vec),
    .pslverr_vec       (pslverr_vec),
    .timeout_pulse     (timeout_pulse)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h @%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model rules written directly from the address map.
  function automatic bit m_hit(input xfer_t t);
    return ((t.addr >> 15) == (BASE >> 15)) && (t.size <= 3'd2);
  endfunction

  function automatic int m_slot(input xfer_t t);
    return int'((t.addr >> 12) & 40'h7);
  endfunction

  function automatic logic [3:0] m_strb(input xfer_t t);
    int nbytes;
    int off;
    nbytes = 1 << t.size;
    off    = int'(t.addr & 40'h3) & ~(nbytes - 1);
    return t.wr ? 4'(((1 << nbytes) - 1) << off) : 4'h0;
  endfunction

  function automatic xfer_t mk(input logic [39:0] a, input logic [2:0] s, input logic w,
                               input logic [31:0] d, input int n, input logic e);
    xfer_t t;
    t.addr = a; t.size = s; t.wr = w; t.wdata = d; t.waits = n; t.err = e;
    return t;
  endfunction

  function automatic xfer_t rnd_xfer();
    xfer_t t;
    int    r;
    r       = $urandom_range(0, 15);
    t.size  = (r == 0) ? 3'd3 : 3'($urandom_range(0, 2));
    t.addr  = BASE | (40'($urandom_range(0, 7)) << 12) | 40'($urandom_range(0, 4095));
    if (r == 1) t.addr = 40'({$urandom, $urandom});
    t.addr  = t.addr & ~40'((1 << t.size) - 1);
    t.wr    = 1'($urandom_range(0, 1));
    t.wdata = $urandom;
    t.waits = (r == 2) ? 20 : $urandom_range(0, 3);
    t.err   = ($urandom_range(0, 5) == 0);
    return t;
  endfunction

  task automatic drive_addr(input xfer_t t);
    hsel = 1'b1; htrans = 2'b10; haddr = t.addr; hwrite = t.wr; hsize = t.size;
    cur_waits = t.waits; cur_err = t.err; acc_cnt = 0;
    for (int i = 0; i < NUM_SLV; i++) slot_data[i] = $urandom;
  endtask

  task automatic drive_idle();
    hsel = 1'b1; htrans = 2'b00;
  endtask

  // Walks one transfer cycle by cycle; k counts cycles after the address phase.
  task automatic run_xfer(input xfer_t t, input bit has_next, input xfer_t nxt);
    bit                 hit, tmo, err;
    int                 r, last, slot;
    logic [NUM_SLV-1:0] oh;
    hit  = m_hit(t);
    slot = m_slot(t);
    tmo  = hit && (t.waits >= TO);
    err  = !hit || tmo || t.err;
    r    = !hit ? 1 : (tmo ? 3 + TO : 4 + t.waits);
    last = err ? r + 1 : r;
    oh   = hit ? NUM_SLV'(1 << slot) : '0;
    for (int k = 1; k <= last; k++) begin
      @(negedge hclk);
      if (k < r) begin
        chk("hready_busy", 64'(hready), 64'(0));
        chk("hresp_busy", 64'(hresp), 64'(0));
        chk("psel", 64'(psel_vec), 64'((k >= 2) ? oh : '0));
        chk("penable", 64'(penable), 64'(k >= 3));
        if (k >= 2) begin
          chk("paddr", 64'(paddr), 64'(t.addr));
          chk("pwrite", 64'(pwrite), 64'(t.wr));
          chk("pstrb", 64'(pstrb), 64'(m_strb(t)));
          if (t.wr) chk("pwdata", 64'(pwdata), 64'(t.wdata));
        end
      end else if (k == r) begin
        if (!err) last_rdata = slot_data[slot];
        chk("psel_end", 64'(psel_vec), 64'(0));
        chk("penable_end", 64'(penable), 64'(0));
        chk("hready_resp", 64'(hready), 64'(!err));
        chk("hresp_resp", 64'(hresp), 64'(err ? 2'b01 : 2'b00));
        chk("hrdata_resp", 64'(hrdata), 64'(last_rdata));
        chk("timeout_pulse", 64'(timeout_pulse), 64'(tmo));
      end else begin
        chk("hready_err2", 64'(hready), 64'(1));
        chk("hresp_err2", 64'(hresp), 64'(2'b01));
        chk("hrdata_err2", 64'(hrdata), 64'(last_rdata));
        chk("timeout_err2", 64'(timeout_pulse), 64'(0));
        chk("psel_err2", 64'(psel_vec), 64'(0));
      end
      if (k == 1) begin
        hwdata = t.wdata;
        drive_idle();
      end
      if (psel_vec != '0 && penable) acc_cnt++;
      if (k == last) begin
        if (has_next) drive_addr(nxt);
        else drive_idle();
      end
    end
    $display("xfer addr=%h size=%0d wr=%0d waits=%0d err=%0d -> resp at +%0d %s",
             t.addr, t.size, t.wr, t.waits, t.err, r, err ? "ERROR" : "OKAY");
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_hready"}, 64'(hready), 64'(1));
    chk({tag, "_hresp"}, 64'(hresp), 64'(0));
    chk({tag, "_hrdata"}, 64'(hrdata), 64'(0));
    chk({tag, "_psel"}, 64'(psel_vec), 64'(0));
    chk({tag, "_penable"}, 64'(penable), 64'(0));
    chk({tag, "_pwrite"}, 64'(pwrite), 64'(0));
    chk({tag, "_paddr"}, 64'(paddr), 64'(0));
    chk({tag, "_pwdata"}, 64'(pwdata), 64'(0));
    chk({tag, "_pstrb"}, 64'(pstrb), 64'(0));
    chk({tag, "_timeout"}, 64'(timeout_pulse), 64'(0));
  endtask

  // Address phases that must not be accepted leave the bridge idle.
  task automatic no_accept(input string tag, input logic s, input logic [1:0] tr, input logic rin);
    hsel = s; htrans = tr; haddr = BASE | 40'h2000; hsize = 3'd2; hwrite = 1'b0; hready_in = rin;
    for (int k = 0; k < 3; k++) begin
      @(negedge hclk);
      chk({tag, "_hready"}, 64'(hready), 64'(1));
      chk({tag, "_psel"}, 64'(psel_vec), 64'(0));
    end
    hready_in = 1'b1;
    drive_idle();
    $display("no-accept %s hsel=%0d htrans=%0d hready_in=%0d", tag, s, tr, rin);
  endtask

  initial begin
    xfer_t t0, t1, q[$];
    for (int i = 0; i < NUM_SLV; i++) slot_data[i] = 32'h0;
    repeat (2) @(negedge hclk);
    chk_reset_vals("rst");
    hrst_b = 1'b1;
    @(negedge hclk);
    chk_reset_vals("post_rst");

    // Zero-wait read of slot 2.
    t0 = mk(40'h00_1000_2004, 3'd2, 1'b0, 32'h0, 0, 1'b0);
    drive_addr(t0);
    slot_data[2] = 32'hCAFE_0001;
    run_xfer(t0, 1'b0, t0);

    // Halfword write with three wait states.
    t0 = mk(40'h00_1000_1006, 3'd1, 1'b1, 32'hBEEF_0000, 3, 1'b0);
    drive_addr(t0);
    run_xfer(t0, 1'b0, t0);

    // PSLVERR read, unmapped region, oversize access, then timeout on slot 5.
    t0 = mk(40'h00_1000_3000, 3'd2, 1'b0, 32'h0, 0, 1'b1);
    drive_addr(t0);
    run_xfer(t0, 1'b0, t0);
    t0 = mk(40'h20_0000_0000, 3'd2, 1'b0, 32'h0, 0, 1'b0);
    drive_addr(t0);
    run_xfer(t0, 1'b0, t0);
    t0 = mk(40'h00_1000_4000, 3'd3, 1'b1, 32'h1234_5678, 0, 1'b0);
    drive_addr(t0);
    run_xfer(t0, 1'b0, t0);
    t0 = mk(40'h00_1000_5010, 3'd2, 1'b0, 32'h0, 40, 1'b0);
    drive_addr(t0);
    run_xfer(t0, 1'b0, t0);

    no_accept("busy", 1'b1, 2'b01, 1'b1);
    no_accept("nosel", 1'b0, 2'b10, 1'b1);
    no_accept("hrdy_lo", 1'b1, 2'b10, 1'b0);

    // Back-to-back reads, second address presented in the DONE cycle.
    t0 = mk(40'h00_1000_6000, 3'd2, 1'b0, 32'h0, 0, 1'b0);
    t1 = mk(40'h00_1000_7008, 3'd2, 1'b0, 32'h0, 1, 1'b0);
    drive_addr(t0);
    run_xfer(t0, 1'b1, t1);
    run_xfer(t1, 1'b0, t1);

    // Randomised bursts of back-to-back transfers.
    for (int b = 0; b < 10; b++) begin
      q.delete();
      for (int i = 0; i < int'($urandom_range(1, 6)); i++) q.push_back(rnd_xfer());
      drive_addr(q[0]);
      for (int i = 0; i < q.size(); i++) begin
        if (i + 1 < q.size()) run_xfer(q[i], 1'b1, q[i+1]);
        else run_xfer(q[i], 1'b0, q[i]);
      end
    end

    // Reset asserted while the slave is still holding PREADY low.
    t0 = mk(40'h00_1000_4000, 3'd2, 1'b1, 32'hA5A5_5A5A, 10, 1'b0);
    drive_addr(t0);
    for (int k = 1; k <= 4; k++) begin
      @(negedge hclk);
      if (k == 1) begin
        hwdata = t0.wdata;
        drive_idle();
      end
      if (psel_vec != '0 && penable) acc_cnt++;
    end
    chk("psel_pre_rst", 64'(psel_vec), 64'(8'h10));
    chk("penable_pre_rst", 64'(penable), 64'(1));
    #2 hrst_b = 1'b0;
    #1 chk_reset_vals("mid_rst");
    @(negedge hclk);
    hrst_b = 1'b1;
    last_rdata = 32'h0;
    for (int k = 0; k < 3; k++) begin
      @(negedge hclk);
      chk_reset_vals("after_rst");
    end
    $display("reset during ACCESS checked");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
